// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (divider enabled by MULDIV_DIV_EN)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             qneg_q, qneg_d;
    logic [WIDTH-1:0] result_q, result_d;
`ifdef MULDIV_DIV_EN
    logic             rneg_q, rneg_d;
    logic             divz_q, divz_d;
`endif

    // Operand signedness and magnitudes for the request being presented
    logic             a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One iteration of the shared hi/lo datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] product, product_s;
    logic [WIDTH-1:0]   final_res;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   quot_s, rem_s;
`endif

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign result = result_q;

    // Decode signedness of the incoming request and form operand magnitudes
    always_comb begin
        a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_sgn = op[2] ? ~op[0] : ~op[1];
        a_neg = a_sgn & a[WIDTH-1];
        b_neg = b_sgn & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // Shift-add multiply step, restoring divide step and final sign fix-up
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
        quot_s = qneg_q ? -step_lo : step_lo;
        rem_s  = rneg_q ? -step_hi : step_hi;
`endif
        product   = {step_hi, step_lo};
        product_s = qneg_q ? -product : product;
        if (!op_q[2]) begin
            final_res = (op_q[1:0] == 2'b00) ? product_s[WIDTH-1:0] : product_s[2*WIDTH-1:WIDTH];
        end else begin
`ifdef MULDIV_DIV_EN
            // Remainder by zero falls out of the datapath as a; only the quotient needs forcing.
            // Signed overflow (MIN / -1) also falls out naturally: quotient MIN, remainder 0.
            if (op_q[1])
                final_res = rem_s;
            else
                final_res = divz_q ? {WIDTH{1'b1}} : quot_s;
`else
            final_res = '0;
`endif
        end
    end

    // Next-state logic: accept requests outside CALC, iterate in CALC
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        qneg_d   = qneg_q;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        rneg_d   = rneg_q;
        divz_d   = divz_q;
`endif
        case (state_q)
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d  = DONE;
                    result_d = final_res;
                end
            end
            default: begin
                if (start) begin
                    state_d = CALC;
                    op_d    = op;
                    cnt_d   = '0;
                    hi_d    = '0;
                    // Multiply: lo holds the multiplier, opnd the multiplicand.
                    // Divide: lo holds the dividend, opnd the divisor.
                    lo_d    = op[2] ? a_mag : b_mag;
                    opnd_d  = op[2] ? b_mag : a_mag;
                    qneg_d  = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                    rneg_d  = a_neg;
                    divz_d  = (b == '0);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            qneg_q   <= 1'b0;
            result_q <= '0;
`ifdef MULDIV_DIV_EN
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            qneg_q   <= qneg_d;
            result_q <= result_d;
`ifdef MULDIV_DIV_EN
            rneg_q   <= rneg_d;
            divz_q   <= divz_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] pu;
        if (!o[2]) begin
            sx = (o[1:0] != 2'b11) ? longint'($signed(x)) : longint'({32'b0, x});
            sy = (o[1:0] <= 2'b01) ? longint'($signed(y)) : longint'({32'b0, y});
            p  = sx * sy;
            pu = p;
            return (o[1:0] == 2'b00) ? pu[31:0] : pu[63:32];
        end
`ifdef MULDIV_DIV_EN
        if (y == 32'h0) return o[1] ? x : 32'hFFFFFFFF;
        if (!o[0]) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return o[1] ? 32'h0 : 32'h80000000;
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end
        q  = sx / sy;
        r  = sx % sy;
        pu = o[1] ? r : q;
        return pu[31:0];
`else
        return 32'h0;
`endif
    endfunction

    // Present a request for one cycle, then scramble inputs to prove they were latched
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input string tag);
        int lat;
        launch(o, x, y);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd32);
        chk({tag, "_res"}, result, exp);
        @(posedge clk); #1;
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_held"}, result, exp);
    endtask

    initial begin
        int lat, ndone;
        logic [2:0]  ro;
        logic [31:0] ra, rb, r1, r2;

        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
`ifdef MULDIV_DIV_EN
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div");
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem");
        run_op(3'b101, 32'd100, 32'd7, 32'd14, "divu");
        run_op(3'b111, 32'd100, 32'd7, 32'd2, "remu");
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_z");
        run_op(3'b111, 32'd5, 32'd0, 32'd5, "remu_z");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");
`else
        run_op(3'b101, 32'd100, 32'd7, 32'd0, "divu_off");
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'd0, "rem_off");
`endif

        // start pulsed while busy must be ignored
        launch(3'b000, 32'd7, 32'hFFFFFFFD);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("ign_res", result, 32'hFFFFFFEB);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("ign_ndone", 32'(ndone), 32'd0);

        // start held high through DONE: back-to-back operations
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd123; b = 32'd456;
        @(posedge clk); #1;
        wait_done(lat);
        r1 = model(3'b000, 32'd123, 32'd456);
        chk("b2b_res1", result, r1);
        op = 3'b011; a = 32'hDEADBEEF; b = 32'h12345678;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_held", result, r1);
        wait_done(lat);
        r2 = model(3'b011, 32'hDEADBEEF, 32'h12345678);
        chk("b2b_lat", 32'(lat), 32'd32);
        chk("b2b_res2", result, r2);
        @(posedge clk); #1;

        // reset mid-operation
        launch(3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF);
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk); rst = 1'b0;
        run_op(3'b000, 32'd3, 32'd4, 32'd12, "post_rst");

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                2: ra = $urandom_range(0, 50);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d_op%0d", i, ro));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the main ALU in the execute stage. It takes the two register-file read operands (rs1/rs2 values) plus funct3, computes over a fixed number of cycles, and presents a 32-bit result for the register-file write-data mux. A start/busy/done handshake lets the control unit stall PC and register writeback until the result is ready.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on a rising edge only when busy=0.
- op  in  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 value (multiplicand/dividend).
- b  in  WIDTH  rs2 value (multiplier/divisor).
- busy  out  1  high while computing; core stalls while busy.
- done  out  1  one-cycle pulse; result valid in that cycle.
- result  out  WIDTH  last completed result; held until the next completion.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 → CALC; latch op, a and b; clear iteration counter.
  - CALC: one iteration per edge. After WIDTH iterations → DONE and load result.
  - DONE: start=1 → CALC (back-to-back, new operands latched); otherwise → IDLE.
- busy = (state==CALC). done = (state==DONE).
- start while busy=1 is ignored; operands in flight are unaffected by input changes.
- Multiply:
  - Operands are converted to magnitudes according to signedness: MUL/MULH both signed; MULHSU a signed, b unsigned; MULHU both unsigned.
  - 32-step shift-add produces a 64-bit unsigned product.
  - The product is negated (two's complement, 64-bit) if the operand signs differ.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring division, 32 steps, on magnitudes (signed ops) or raw values (unsigned ops).
  - Signed quotient is negated if the signs of a and b differ; signed remainder takes the sign of a.
- Special cases: the result is forced at the CALC→DONE transition; latency is unchanged.
  - b=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - DIV with a=0x80000000, b=0xFFFFFFFF returns 0x80000000; REM returns 0.
- All arithmetic is modulo 2^WIDTH on the output; no exceptions or flags.

## Timing
- Reset values (asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0.
- start sampled at edge E0 → busy=1 after E0 → iterations on edges E1..E32.
- State=DONE after E32: busy=0, done=1, result valid from E32 until the next completion.
- Latency is 33 cycles from start sampling to the done cycle, identical for all ops and special cases.
- Throughput with start held high in DONE is one operation per 33 cycles.
- Reset asserted mid-operation aborts the operation immediately:
  - outputs return to reset values and no done pulse is produced.
  - The first start after rst deasserts is accepted normally.
- No combinational path from start, a, b or op to any output.

## Configuration
- MULDIV_DIV_EN defined: full unit; all eight ops are implemented as above.
- MULDIV_DIV_EN undefined: no divider datapath is synthesized.
  - Ops 1xx are still accepted with the same handshake and 33-cycle latency, so the core cannot hang.
  - Ops 1xx return result=0. Multiply behaviour is unchanged.

## Test plan
- MUL a=7, b=0xFFFFFFFD → done exactly 33 cycles after start, result 0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14 and REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
- Handshake:
  - start pulsed at cycle 10 of a busy op → ignored; the first result is unchanged and there is only one done pulse.
  - start held high in DONE → back-to-back op accepted; result is held between done pulses.
- rst asserted at iteration 16 → busy=0, done=0, result=0 immediately; a new MUL 3×4 afterwards → 12. Without MULDIV_DIV_EN, DIVU 100/7 → 0 after 33 cycles.
